wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback stage + integer register file directly downstream of the ALU. Accepts ALU results
//  (rd, wen, data) via valid/ready into a small pending-write FIFO, drains it into a 32-entry
//  regfile, and serves two combinational read ports that feed the ALU A/B operands.
//  Reports read-after-write hazards against pending writes; counts retired results.
// PARAMETERS
//  WIDTH      32  data width of registers and ALU results
//  NREGS      32  number of architectural registers (x0 hardwired zero)
//  DEPTH      2   pending-write FIFO entries (power of two, >=1)
//  CNT_WIDTH  32  width of retire counter (wraps)
// PORTS
//  clk          in   1                  clock, all state updates on rising edge
//  rst          in   1                  synchronous, active-high reset
//  in_valid     in   1                  ALU result valid
//  in_ready     out  1                  stage can accept this cycle
//  in_rd        in   $clog2(NREGS)      destination register index
//  in_wen       in   1                  result writes the regfile
//  in_data      in   WIDTH              ALU Result
//  wb_stall     in   1                  1 = do not drain FIFO head this cycle
//  rs1_idx      in   $clog2(NREGS)      read port 1 index
//  rs1_data     out  WIDTH              read port 1 data (combinational)
//  rs1_hazard   out  1                  rs1 depends on a pending write
//  rs2_idx      in   $clog2(NREGS)      read port 2 index
//  rs2_data     out  WIDTH              read port 2 data (combinational)
//  rs2_hazard   out  1                  rs2 depends on a pending write
//  retire_cnt   out  CNT_WIDTH          number of entries drained since reset
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): FIFO emptied (pending entries discarded, even mid-stall), all
//    regs=0, retire_cnt=0. During/after reset in_ready=1, hazards=0, rs*_data=0.
//  - Accept: push when in_valid&&in_ready. in_ready = (count<DEPTH) || !wb_stall, i.e. a full FIFO
//    accepts when the head drains in the same cycle. in_valid with in_ready=0 => no push; the
//    producer holds its inputs stable.
//  - Drain: when count>0 && !wb_stall, head pops at the edge; if head.wen && head.rd!=0 the
//    regfile is written with head.data at that edge. retire_cnt+=1 per pop (wen=0 and rd=0
//    entries also retire), wrapping at 2^CNT_WIDTH. Empty FIFO: no pop, no count.
//  - Latency: result accepted at edge N is in the regfile at edge N+1 at the earliest (one
//    cycle per older pending entry, plus stall cycles).
//  - Simultaneous push+pop: both occur, count unchanged; pointers wrap modulo DEPTH.
//  - Read: idx==0 => data 0, hazard 0. Otherwise data = regfile[idx] (value before this edge's write).
//  - Pending match: a FIFO entry with wen=1, rd==idx!=0. The input-side entry being pushed this
//    cycle is not a pending match.
//  - Regfile write to x0 is never performed; reg 0 reads 0 regardless.
// CONFIGURATION
//  WB_BYPASS_EN defined: rs*_data = data of the youngest pending match (else regfile);
//    rs*_hazard tied 0.
//  WB_BYPASS_EN undefined: rs*_data = regfile only; rs*_hazard = 1 iff any pending match exists,
//    upstream must stall.
// STRUCTURE
//  - Shared package wb_pkgs: reg_idx_t (logic [$clog2(NREGS)-1:0]), wb_entry_t packed struct
//    {rd, wen, data}, constant REG_ZERO = '0.
//  - Sub-module wb_fifo: DEPTH-entry FIFO of wb_entry_t with push/pop, count, and a flat view of
//    valid entries ordered by age (for match search). The regfile array, read muxes, match
//    logic and retire counter live in wb_regfile.
// TESTING
//  1 Reset: write x5=7, assert rst one cycle -> rs1_idx=5 reads 0, retire_cnt=0, in_ready=1.
//  2 Basic wb: push rd=3,wen=1,data=0xDEADBEEF, wb_stall=0 -> next cycle rs1(3)=0xDEADBEEF, retire_cnt=1.
//  3 x0: push rd=0,wen=1,data=0x1234 -> rs2(0)=0 always, retire_cnt increments, hazard on idx 0 stays 0.
//  4 Full/backpressure: wb_stall=1, push 2 entries -> in_ready=0 on 3rd; drop wb_stall with in_valid=1
//    -> push+pop same cycle, count stays 2, order preserved (rd=1,2,3 written in that order).
//  5 Hazard/bypass: stall, push rd=4 data=5 then rd=4 data=9, rs1_idx=4 -> bypass build: rs1_data=9,
//    hazard=0; non-bypass build: rs1_data=old x4, rs1_hazard=1 until both drained.
//  6 Counter wrap (CNT_WIDTH=4): retire 17 entries -> retire_cnt=1; wen=0 entries count, regs unchanged.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared types for the writeback stage: register index, pending-write entry, x0 constant.
// Optional build macro used by wb_regfile: WB_BYPASS_EN.
package wb_pkgs;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int IDX_W = $clog2(NREGS);

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t           rd;
    logic               wen;
    logic [WIDTH-1:0]   data;
  } wb_entry_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/wb_regfile_fifo.sv
// Pending-write FIFO of wb_entry_t; exposes head, occupancy and an age-ordered view (index 0 = oldest).
// Caller guarantees no pop when empty and no push when full unless popping in the same cycle.
module wb_fifo
  import wb_pkgs::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  wb_entry_t             i_ent,
  input  logic                  i_pop,
  output wb_entry_t             o_head,
  output logic [CW-1:0]         o_count,
  output wb_entry_t [DEPTH-1:0] o_ents,
  output logic [DEPTH-1:0]      o_vld
);
  wb_entry_t      r_mem [DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_ent;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && i_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_comb begin
    int w_k;
    o_ents = '0;
    o_vld  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_k = int'(r_rd_ptr) + i;
      if (w_k >= DEPTH) w_k = w_k - DEPTH;
      o_ents[i] = r_mem[w_k];
      o_vld[i]  = (i < int'(r_count));
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: pending-write FIFO drained into a 32-entry regfile, two combinational read ports,
// RAW hazard flags and a wrapping retire counter. Build macro WB_BYPASS_EN forwards pending data instead.
module wb_regfile
  import wb_pkgs::*;
#(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_W-1:0]     in_rd,
  input  logic                 in_wen,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 wb_stall,
  input  logic [IDX_W-1:0]     rs1_idx,
  output logic [WIDTH-1:0]     rs1_data,
  output logic                 rs1_hazard,
  input  logic [IDX_W-1:0]     rs2_idx,
  output logic [WIDTH-1:0]     rs2_data,
  output logic                 rs2_hazard,
  output logic [CNT_WIDTH-1:0] retire_cnt
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]      r_regs [NREGS];
  logic [CNT_WIDTH-1:0]  r_retire;

  wb_entry_t             w_in_ent;
  wb_entry_t             w_head;
  logic [CW-1:0]         w_count;
  wb_entry_t [DEPTH-1:0] w_ents;
  logic [DEPTH-1:0]      w_vld;
  logic                  w_push;
  logic                  w_pop;

  // A full FIFO still accepts when its head leaves in the same cycle.
  assign in_ready = rst || (int'(w_count) < DEPTH) || !wb_stall;
  assign w_push   = in_valid && in_ready && !rst;
  assign w_pop    = (w_count != '0) && !wb_stall && !rst;

  assign w_in_ent.rd   = in_rd;
  assign w_in_ent.wen  = in_wen;
  assign w_in_ent.data = in_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_ent   (w_in_ent),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_ents  (w_ents),
    .o_vld   (w_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_retire <= '0;
    end else if (w_pop) begin
      r_retire <= r_retire + 1'b1;
      if (w_head.wen && (w_head.rd != REG_ZERO)) begin
        r_regs[w_head.rd] <= w_head.data;
      end
    end
  end

  assign retire_cnt = r_retire;

  logic [IDX_W-1:0] w_idx  [2];
  logic [WIDTH-1:0] w_rdat [2];
  logic             w_haz  [2];

  assign w_idx[0] = rs1_idx;
  assign w_idx[1] = rs2_idx;

  // Entries are scanned oldest to youngest so the last match wins the bypass.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdat[p] = '0;
      w_haz[p]  = 1'b0;
      if (!rst && (w_idx[p] != REG_ZERO)) begin
        w_rdat[p] = r_regs[w_idx[p]];
        for (int i = 0; i < DEPTH; i++) begin
          if (w_vld[i] && w_ents[i].wen && (w_ents[i].rd == w_idx[p])) begin
`ifdef WB_BYPASS_EN
            w_rdat[p] = w_ents[i].data;
`else
            w_haz[p]  = 1'b1;
`endif
          end
        end
      end
    end
  end

  assign rs1_data   = w_rdat[0];
  assign rs2_data   = w_rdat[1];
  assign rs1_hazard = w_haz[0];
  assign rs2_hazard = w_haz[1];
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue/array model of the writeback stage.
module tb_wb_regfile;
  localparam int DEPTH = 2;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_wen, wb_stall;
  logic [4:0]    in_rd, rs1_idx, rs2_idx;
  logic [31:0]   in_data, rs1_data, rs2_data;
  logic          rs1_hazard, rs2_hazard;
  logic [CW-1:0] retire_cnt;

  always #5 clk = ~clk;

  wb_regfile #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_data(in_data), .wb_stall(wb_stall),
    .rs1_idx(rs1_idx), .rs1_data(rs1_data), .rs1_hazard(rs1_hazard),
    .rs2_idx(rs2_idx), .rs2_data(rs2_data), .rs2_hazard(rs2_hazard),
    .retire_cnt(retire_cnt)
  );

  typedef struct { int rd; bit wen; logic [31:0] data; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_regs [32];
  int          m_cnt;
  bit          m_known = 0;
  bit          m_blocked;
  int          vectors = 0;
  int          errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural view: youngest pending write to idx, or the committed value.
  task automatic model_read(input bit r, input int idx, output logic [31:0] d, output bit h);
    d = 0;
    h = 0;
    if (r || idx == 0) return;
    d = m_regs[idx];
    foreach (m_q[i]) begin
      if (m_q[i].wen && m_q[i].rd == idx) begin
`ifdef WB_BYPASS_EN
        d = m_q[i].data;
`else
        h = 1;
`endif
      end
    end
  endtask

  // One clock: drive at negedge, compare shortly after, then advance the model past the next edge.
  task automatic cycle(input bit r, input bit v, input int rd, input bit w, input logic [31:0] d,
                       input bit s, input int a, input int b);
    logic [31:0] ed;
    bit          eh, rdy;
    ent_t        e;
    @(negedge clk);
    rst = r; in_valid = v; in_rd = rd[4:0]; in_wen = w; in_data = d;
    wb_stall = s; rs1_idx = a[4:0]; rs2_idx = b[4:0];
    #1;
    rdy = r || (m_q.size() < DEPTH) || !s;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    model_read(r, a, ed, eh);
    chk("rs1_data", rs1_data, ed);
    chk("rs1_hazard", {31'b0, rs1_hazard}, {31'b0, eh});
    model_read(r, b, ed, eh);
    chk("rs2_data", rs2_data, ed);
    chk("rs2_hazard", {31'b0, rs2_hazard}, {31'b0, eh});
    if (m_known) chk("retire_cnt", {28'b0, retire_cnt}, m_cnt);
    m_blocked = v && !rdy && !r;
    if (r) begin
      m_q.delete();
      foreach (m_regs[i]) m_regs[i] = 0;
      m_cnt   = 0;
      m_known = 1;
    end else begin
      if (m_q.size() > 0 && !s) begin
        e = m_q.pop_front();
        if (e.wen && e.rd != 0) m_regs[e.rd] = e.data;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (v && rdy) m_q.push_back('{rd, w, d});
    end
  endtask

  initial begin
    bit          hv, hw;
    int          hrd;
    logic [31:0] hd;
    rst = 1; in_valid = 0; in_rd = 0; in_wen = 0; in_data = 0; wb_stall = 0; rs1_idx = 0; rs2_idx = 0;

    // Reset clears a previously written register.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 5, 1, 32'd7, 0, 5, 0);
    cycle(0, 0, 0, 0, 0, 0, 5, 0);
    cycle(0, 0, 0, 0, 0, 0, 5, 0);
    chk("x5_written", rs1_data, 32'd7);
    cycle(1, 0, 0, 0, 0, 0, 5, 0);
    chk("rst_rs1", rs1_data, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 5, 0);
    chk("post_rst_x5", rs1_data, 32'd0);
    chk("post_rst_cnt", {28'b0, retire_cnt}, 32'd0);

    // Basic writeback.
    cycle(0, 1, 3, 1, 32'hDEADBEEF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 3, 0);
    cycle(0, 0, 0, 0, 0, 0, 3, 0);
    chk("x3_wb", rs1_data, 32'hDEADBEEF);
    chk("cnt_1", {28'b0, retire_cnt}, 32'd1);

    // Writes to x0 retire but never land.
    cycle(0, 1, 0, 1, 32'h1234, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_hazard", {31'b0, rs2_hazard}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_data", rs2_data, 32'd0);
    chk("cnt_2", {28'b0, retire_cnt}, 32'd2);

    // Full FIFO backpressure, then push and pop in the same cycle.
    cycle(0, 1, 1, 1, 32'h11, 1, 0, 0);
    cycle(0, 1, 2, 1, 32'h22, 1, 0, 0);
    cycle(0, 1, 3, 1, 32'h33, 1, 0, 0);
    chk("full_ready", {31'b0, in_ready}, 32'd0);
    cycle(0, 1, 3, 1, 32'h33, 0, 0, 0);
    chk("drain_ready", {31'b0, in_ready}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("order_x1", rs1_data, 32'h11);
    cycle(0, 0, 0, 0, 0, 0, 2, 0);
    chk("order_x2", rs1_data, 32'h22);
    cycle(0, 0, 0, 0, 0, 0, 3, 0);
    chk("order_x3", rs1_data, 32'h33);
    chk("cnt_5", {28'b0, retire_cnt}, 32'd5);

    // Two pending writes to x4 over an old value.
    cycle(0, 1, 4, 1, 32'd1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 4, 1, 32'd5, 1, 0, 0);
    cycle(0, 1, 4, 1, 32'd9, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 4, 0);
`ifdef WB_BYPASS_EN
    chk("byp_data", rs1_data, 32'd9);
    chk("byp_hazard", {31'b0, rs1_hazard}, 32'd0);
`else
    chk("raw_data", rs1_data, 32'd1);
    chk("raw_hazard", {31'b0, rs1_hazard}, 32'd1);
`endif
    cycle(0, 0, 0, 0, 0, 0, 4, 0);
    cycle(0, 0, 0, 0, 0, 0, 4, 0);
    cycle(0, 0, 0, 0, 0, 0, 4, 0);
    chk("x4_final", rs1_data, 32'd9);
    chk("x4_clear", {31'b0, rs1_hazard}, 32'd0);

    // Counter wrap: 17 retires from reset, wen=0 entries leave x7 alone.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 7, 1, 32'h77, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 7, 0, $urandom, 0, 7, 0);
    cycle(0, 0, 0, 0, 0, 0, 7, 0);
    cycle(0, 0, 0, 0, 0, 0, 7, 0);
    chk("cnt_wrap", {28'b0, retire_cnt}, 32'd1);
    chk("x7_kept", rs1_data, 32'h77);

    // Randomized traffic; small index range to provoke matches.
    m_blocked = 0; hv = 0; hrd = 0; hw = 0; hd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!m_blocked) begin
        hv  = ($urandom_range(0, 9) < 7);
        hrd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        hw  = ($urandom_range(0, 4) != 0);
        hd  = $urandom;
      end
      cycle(($urandom_range(0, 63) == 0), hv, hrd, hw, hd, ($urandom_range(0, 1) == 1),
            $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
